cpu1_loader: RTL and testbench

Boot/load controller for the `cpu1` core. It holds the core in reset while it receives a program image over a byte stream and writes it as 16-bit words into the instruction RAM that feeds `in_rom_data`. It checks an XOR checksum, then releases the core. It sits between the host link (UART/SPI byte receiver) and the `cpu1` reset and instruction-memory write port.

---
 rtl/cpu1_pkg.sv | 26 ++
 rtl/cpu1_loader_timer.sv | 39 +++
 rtl/cpu1_loader.sv | 152 +++++++++++++++
 tb/tb_cpu1_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu1_pkg.sv
// Shared definitions for the cpu1 boot loader: state encoding, error codes and
// a helper that identifies the byte-accepting states.
package cpu1_pkg;

  typedef enum logic [2:0] {
    S_LEN,
    S_LO,
    S_HI,
    S_SUM,
    S_RUN,
    S_ERR
  } ldr_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SUM     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  function automatic logic is_loading(input ldr_state_e s);
    return (s == S_LEN) || (s == S_LO) || (s == S_HI) || (s == S_SUM);
  endfunction

  function automatic logic is_timed(input ldr_state_e s);
    return (s == S_LO) || (s == S_HI) || (s == S_SUM);
  endfunction

endpackage

// File: rtl/cpu1_loader_timer.sv
// Inter-byte idle counter. Expires during the TIMEOUT-th consecutive idle tick;
// never expires when TIMEOUT is 0.
module cpu1_loader_timer #(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam logic        ENABLED = (TIMEOUT != 0);
  localparam logic [15:0] LAST    = 16'(TIMEOUT - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Combinational so the error is taken on the edge that ends the last idle cycle.
  assign expired = ENABLED & tick & ~clear & (count_q == LAST);

endmodule

// File: rtl/cpu1_loader.sv
// Boot loader for cpu1: receives a LEN/payload/SUM byte frame, writes 16-bit
// words into instruction RAM, verifies the XOR checksum and releases the core.
module cpu1_loader
  import cpu1_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_load,
  input  logic [7:0]  in_rx_data,
  input  logic        in_rx_valid,
  output logic        out_rx_ready,
  output logic [7:0]  out_irom_addr,
  output logic [15:0] out_irom_data,
  output logic        out_irom_wr,
  output logic        out_cpu_rst,
  output logic        out_busy,
  output logic        out_done,
  output logic [1:0]  out_err_code
);

  ldr_state_e  state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  xor_q, xor_d;
  logic [1:0]  err_q, err_d;
  logic        wr_q, wr_d;
  logic [7:0]  waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic handshake;
  logic tmr_clear;
  logic tmr_tick;
  logic tmr_expired;

  assign out_rx_ready = is_loading(state_q) & ~in_load & ~in_rst;
  assign handshake    = in_rx_valid & out_rx_ready;

  assign tmr_tick  = is_timed(state_q) & ~handshake;
  assign tmr_clear = handshake | in_load | ~is_timed(state_q);

  cpu1_loader_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (in_clk),
    .rst    (in_rst),
    .clear  (tmr_clear),
    .tick   (tmr_tick),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    xor_d   = xor_q;
    err_d   = err_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    if (in_load) begin
      state_d = S_LEN;
      err_d   = ERR_NONE;
    end else if (handshake) begin
      unique case (state_q)
        S_LEN: begin
          cnt_d   = (in_rx_data == 8'd0) ? 9'd256 : {1'b0, in_rx_data};
          addr_d  = 8'd0;
          xor_d   = in_rx_data;
          state_d = S_LO;
        end
        S_LO: begin
          lo_d    = in_rx_data;
          xor_d   = xor_q ^ in_rx_data;
          state_d = S_HI;
        end
        S_HI: begin
          xor_d   = xor_q ^ in_rx_data;
          wr_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {in_rx_data, lo_q};
          addr_d  = addr_q + 8'd1;
          cnt_d   = cnt_q - 9'd1;
          state_d = (cnt_q == 9'd1) ? S_SUM : S_LO;
        end
        S_SUM: begin
          if (in_rx_data == xor_q) begin
            state_d = S_RUN;
          end else begin
            state_d = S_ERR;
            err_d   = ERR_SUM;
          end
        end
        default: ;
      endcase
    end else if (tmr_expired) begin
      state_d = S_ERR;
      err_d   = ERR_TIMEOUT;
    end

    // Status outputs are registered from the next state so they track state_q.
    cpu_rst_d = (state_d != S_RUN);
    busy_d    = is_loading(state_d);
    done_d    = (state_d == S_RUN);
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q   <= S_LEN;
      cnt_q     <= '0;
      addr_q    <= '0;
      lo_q      <= '0;
      xor_q     <= '0;
      err_q     <= ERR_NONE;
      wr_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      lo_q      <= lo_d;
      xor_q     <= xor_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out_irom_wr   = wr_q;
  assign out_irom_addr = waddr_q;
  assign out_irom_data = wdata_q;
  assign out_cpu_rst   = cpu_rst_q;
  assign out_busy      = busy_q;
  assign out_done      = done_q;
  assign out_err_code  = err_q;

endmodule

// File: tb/tb_cpu1_loader.sv
// Bench for cpu1_loader (TIMEOUT=4): cycle-exact vector table, hand-written
// timeout and long-frame sequences, and random frames checked by a frame model.
module tb_cpu1_loader;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b1;
  logic        in_load = 1'b0;
  logic [7:0]  in_rx_data = 8'd0;
  logic        in_rx_valid = 1'b0;
  logic        out_rx_ready;
  logic [7:0]  out_irom_addr;
  logic [15:0] out_irom_data;
  logic        out_irom_wr;
  logic        out_cpu_rst;
  logic        out_busy;
  logic        out_done;
  logic [1:0]  out_err_code;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] wr_log[$];

  always #5 in_clk = ~in_clk;

  cpu1_loader #(
    .TIMEOUT(4)
  ) dut (
    .in_clk       (in_clk),
    .in_rst       (in_rst),
    .in_load      (in_load),
    .in_rx_data   (in_rx_data),
    .in_rx_valid  (in_rx_valid),
    .out_rx_ready (out_rx_ready),
    .out_irom_addr(out_irom_addr),
    .out_irom_data(out_irom_data),
    .out_irom_wr  (out_irom_wr),
    .out_cpu_rst  (out_cpu_rst),
    .out_busy     (out_busy),
    .out_done     (out_done),
    .out_err_code (out_err_code)
  );

  // Record every RAM write as {addr, data}, sampled mid-cycle.
  always @(negedge in_clk) begin
    if (out_irom_wr === 1'b1) wr_log.push_back({out_irom_addr, out_irom_data});
  end

  typedef struct {
    logic        rst;
    logic        ld;
    logic        vld;
    logic [7:0]  data;
    logic        exp_ready;
    logic [29:0] exp_out;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic ld, input logic v,
                              input logic [7:0] d, input logic rdy,
                              input logic wr, input logic [7:0] a,
                              input logic [15:0] wd, input logic crst,
                              input logic busy, input logic done,
                              input logic [1:0] err);
    vec_t t;
    t.rst = r; t.ld = ld; t.vld = v; t.data = d; t.exp_ready = rdy;
    t.exp_out = {wr, a, wd, crst, busy, done, err};
    return t;
  endfunction

  function automatic logic [29:0] outs();
    return {out_irom_wr, out_irom_addr, out_irom_data, out_cpu_rst,
            out_busy, out_done, out_err_code};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ld, input logic v,
                               input logic [7:0] d);
    in_rst = r; in_load = ld; in_rx_valid = v; in_rx_data = d;
    #1;
  endtask

  task automatic stepCycle();
    @(posedge in_clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] d);
    applyStimulus(1'b0, 1'b0, 1'b1, d);
    stepCycle();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    stepCycle();
  endtask

  task automatic loadPulse();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    stepCycle();
    wr_log.delete();
  endtask

  initial begin
    // rst ld vld data rdy | wr addr data crst busy done err
    tbl.push_back(mk(1,0,0,8'h00,0, 0,8'h00,16'h0000,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h02,1, 0,8'h00,16'h0000,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h34,1, 0,8'h00,16'h0000,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h12,1, 1,8'h00,16'h1234,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h78,1, 0,8'h00,16'h1234,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h56,1, 1,8'h01,16'h5678,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h0A,1, 0,8'h01,16'h5678,0,0,1,2'd0));
    tbl.push_back(mk(0,0,1,8'hFF,0, 0,8'h01,16'h5678,0,0,1,2'd0));
    tbl.push_back(mk(0,1,1,8'h55,0, 0,8'h01,16'h5678,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h02,1, 0,8'h01,16'h5678,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h34,1, 0,8'h01,16'h5678,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h12,1, 1,8'h00,16'h1234,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h78,1, 0,8'h00,16'h1234,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h56,1, 1,8'h01,16'h5678,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h0B,1, 0,8'h01,16'h5678,1,0,0,2'd1));
    tbl.push_back(mk(0,0,1,8'h0B,0, 0,8'h01,16'h5678,1,0,0,2'd1));
    tbl.push_back(mk(0,1,0,8'h00,0, 0,8'h01,16'h5678,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h02,1, 0,8'h01,16'h5678,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h34,1, 0,8'h01,16'h5678,1,1,0,2'd0));
    tbl.push_back(mk(0,1,1,8'h12,0, 0,8'h01,16'h5678,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h01,1, 0,8'h01,16'h5678,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'hAB,1, 0,8'h01,16'h5678,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'hCD,1, 1,8'h00,16'hCDAB,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h67,1, 0,8'h00,16'hCDAB,0,0,1,2'd0));
    tbl.push_back(mk(0,1,0,8'h00,0, 0,8'h00,16'hCDAB,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h02,1, 0,8'h00,16'hCDAB,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h11,1, 0,8'h00,16'hCDAB,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h22,1, 1,8'h00,16'h2211,1,1,0,2'd0));
    tbl.push_back(mk(1,0,1,8'h33,0, 0,8'h00,16'h0000,1,1,0,2'd0));
    tbl.push_back(mk(0,0,1,8'h01,1, 0,8'h00,16'h0000,1,1,0,2'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].rst, tbl[i].ld, tbl[i].vld, tbl[i].data);
      checkOutput($sformatf("vec%0d_ready", i), {31'd0, out_rx_ready}, {31'd0, tbl[i].exp_ready});
      stepCycle();
      checkOutput($sformatf("vec%0d_outs", i), {2'b00, outs()}, {2'b00, tbl[i].exp_out});
    end

    // Timeout: three idle cycles tolerated, the fourth errors.
    loadPulse();
    sendByte(8'h01);
    repeat (3) idleCycle();
    checkOutput("tmo_3idle_err", {30'd0, out_err_code}, 32'd0);
    checkOutput("tmo_3idle_busy", {31'd0, out_busy}, 32'd1);
    idleCycle();
    checkOutput("tmo_4idle_err", {30'd0, out_err_code}, 32'd2);
    checkOutput("tmo_4idle_busy", {31'd0, out_busy}, 32'd0);
    checkOutput("tmo_4idle_cpurst", {31'd0, out_cpu_rst}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h11);
    checkOutput("tmo_err_ready", {31'd0, out_rx_ready}, 32'd0);
    stepCycle();

    // Stalls of three cycles between every byte still load successfully.
    loadPulse();
    sendByte(8'h01);
    repeat (3) idleCycle();
    sendByte(8'h11);
    repeat (3) idleCycle();
    sendByte(8'h22);
    repeat (3) idleCycle();
    sendByte(8'h32);
    checkOutput("stall3_done", {31'd0, out_done}, 32'd1);
    checkOutput("stall3_err", {30'd0, out_err_code}, 32'd0);
    checkOutput("stall3_nwr", wr_log.size(), 32'd1);
    if (wr_log.size() > 0) checkOutput("stall3_wr0", {8'd0, wr_log[0]}, 32'h00002211);

    // LEN=0 means 256 words; word i carries value i, so the XOR sum is 0.
    loadPulse();
    sendByte(8'h00);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      sendByte(b);
      sendByte(8'h00);
    end
    checkOutput("len0_before_sum_cpurst", {31'd0, out_cpu_rst}, 32'd1);
    sendByte(8'h00);
    checkOutput("len0_cpurst", {31'd0, out_cpu_rst}, 32'd0);
    checkOutput("len0_done", {31'd0, out_done}, 32'd1);
    checkOutput("len0_nwr", wr_log.size(), 32'd256);
    if (wr_log.size() == 256) begin
      checkOutput("len0_first", {8'd0, wr_log[0]}, 32'h00000000);
      checkOutput("len0_last", {8'd0, wr_log[255]}, 32'h00FF00FF);
    end

    // Reload from the running state.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    stepCycle();
    checkOutput("reload_cpurst", {31'd0, out_cpu_rst}, 32'd1);
    checkOutput("reload_done", {31'd0, out_done}, 32'd0);

    // Random frames against a frame-level model.
    for (int f = 0; f < 30; f++) begin
      int n;
      int tmo_at;
      int exp_words;
      logic [7:0] x;
      logic [7:0] frame[$];
      int gaps[$];
      bit bad;
      logic [1:0] exp_err;
      logic exp_done;

      n = $urandom_range(1, 8);
      frame.delete();
      gaps.delete();
      frame.push_back(8'(n));
      x = 8'(n);
      for (int k = 0; k < 2 * n; k++) begin
        logic [7:0] b;
        b = 8'($urandom);
        frame.push_back(b);
        x = x ^ b;
      end
      bad = ($urandom_range(0, 3) == 0);
      frame.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
      for (int k = 0; k < frame.size(); k++) begin
        gaps.push_back(($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 6));
      end

      tmo_at = -1;
      for (int k = 1; k < frame.size(); k++) begin
        if (gaps[k] >= 4 && tmo_at < 0) tmo_at = k;
      end
      exp_words = (tmo_at >= 0) ? (tmo_at - 1) / 2 : n;
      exp_err   = (tmo_at >= 0) ? 2'd2 : (bad ? 2'd1 : 2'd0);
      exp_done  = (tmo_at < 0) && !bad;

      loadPulse();
      for (int k = 0; k < frame.size(); k++) begin
        repeat (gaps[k]) idleCycle();
        sendByte(frame[k]);
      end
      repeat (2) idleCycle();

      checkOutput($sformatf("rnd%0d_nwr", f), wr_log.size(), exp_words);
      for (int w = 0; w < exp_words && w < wr_log.size(); w++) begin
        checkOutput($sformatf("rnd%0d_wr%0d", f, w), {8'd0, wr_log[w]},
                    {8'd0, 8'(w), frame[2 * w + 2], frame[2 * w + 1]});
      end
      checkOutput($sformatf("rnd%0d_err", f), {30'd0, out_err_code}, {30'd0, exp_err});
      checkOutput($sformatf("rnd%0d_done", f), {31'd0, out_done}, {31'd0, exp_done});
      checkOutput($sformatf("rnd%0d_cpurst", f), {31'd0, out_cpu_rst}, {31'd0, !exp_done});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
